// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, receiver state encoding and
// the default bit period. Shared by the receiver and the matching transmitter.
package uart_pkg;

  localparam int unsigned PARITY_NONE          = 0;
  localparam int unsigned PARITY_EVEN          = 1;
  localparam int unsigned PARITY_ODD           = 2;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 27;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// configurable reset value so an idle-high line does not fake an edge.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, start-glitch rejection,
// parity/framing flags and a one-word holding register with overrun detect.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = PARITY_EVEN,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic                 clk_3125,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk_3125),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 break_wait_q, break_wait_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 bit_tick;
  logic                 commit;
  logic                 fe_commit;

  // Frame FSM and bit timer
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shreg_d      = shreg_q;
    pe_d         = pe_q;
    fe_d         = fe_q;
    break_wait_d = break_wait_q & ~rx_s;
    commit       = 1'b0;
    fe_commit    = fe_q;
    bit_tick     = (cnt_q == BIT_END);

    case (state_q)
      RX_IDLE: begin
        cnt_d      = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        pe_d       = 1'b0;
        fe_d       = 1'b0;
        // After a break the line must return high before a new start counts
        if (!rx_s && !break_wait_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (MSB_FIRST != 0) shreg_d = {shreg_q[DATA_BITS-2:0], rx_s};
          else                shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT)
            state_d = (PARITY_MODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          state_d = RX_STOP;
          if (PARITY_MODE == PARITY_ODD) pe_d = (rx_s != ~^shreg_q);
          else                           pe_d = (rx_s != ^shreg_q);
        end
      end
      RX_STOP: begin
        if (bit_tick) begin
          cnt_d      = '0;
          stop_cnt_d = stop_cnt_q + 1'b1;
          fe_d       = fe_q | ~rx_s;
          fe_commit  = fe_q | ~rx_s;
          if (stop_cnt_q == LAST_STOP) begin
            commit       = 1'b1;
            break_wait_d = ~rx_s;
            state_d      = RX_IDLE;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Holding register and handshake
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;
    busy_d    = (state_d != RX_IDLE);

    if (valid_q && rx_ready) valid_d = 1'b0;
    if (commit) begin
      if (valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = shreg_q;
        perr_d  = pe_q;
        ferr_d  = fe_commit;
      end
    end
  end

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shreg_q      <= '0;
      pe_q         <= 1'b0;
      fe_q         <= 1'b0;
      break_wait_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shreg_q      <= shreg_d;
      pe_q         <= pe_d;
      fe_q         <= fe_d;
      break_wait_q <= break_wait_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = overrun_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three parameter variants, expected
// words queued at stimulus time and compared against words the DUT delivers.
module tb_uart_rx_param;

  localparam int CPB  = 27;
  localparam int HALF = CPB / 2;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_ready = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic [7:0] data_a, data_b, data_c;
  logic valid_a, valid_b, valid_c;
  logic pe_a, pe_b, pe_c;
  logic fe_a, fe_b, fe_c;
  logic ovr_a, ovr_b, ovr_c;
  logic busy_a, busy_b, busy_c;

  int n_cmp = 0;
  int n_fail = 0;

  word_t exp_q[$];
  word_t got_a[$], got_b[$], got_c[$];
  int vcyc_a = 0;
  int ovr_cnt_a = 0;

  always #5 clk = ~clk;

  // Defaults: even parity, 1 stop, MSB first
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(1)) dut_a (
    .clk_3125(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a), .rx_ready(rx_ready),
    .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_overrun(ovr_a), .rx_busy(busy_a));

  // Odd parity, LSB first
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .MSB_FIRST(0)) dut_b (
    .clk_3125(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b), .rx_ready(rx_ready),
    .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_overrun(ovr_b), .rx_busy(busy_b));

  // Two stop bits
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .MSB_FIRST(1)) dut_c (
    .clk_3125(clk), .rst(rst), .rx(rx_c), .rx_data(data_c), .rx_valid(valid_c), .rx_ready(rx_ready),
    .rx_parity_err(pe_c), .rx_frame_err(fe_c), .rx_overrun(ovr_c), .rx_busy(busy_c));

  // Collect accepted words and count valid/overrun cycles
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a && rx_ready) got_a.push_back({data_a, pe_a, fe_a});
      if (valid_b && rx_ready) got_b.push_back({data_b, pe_b, fe_b});
      if (valid_c && rx_ready) got_c.push_back({data_c, pe_c, fe_c});
      if (valid_a) vcyc_a++;
      if (ovr_a) ovr_cnt_a++;
    end
  end

  task automatic set_rx(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic build_frame(input logic [7:0] d, input bit msbf, input int pmode, input bit flip_par,
                             input int nstop, input logic last_stop, output logic [15:0] f, output int n);
    logic p;
    f = '1;
    n = 0;
    f[n] = 1'b0; n = n + 1;
    for (int i = 0; i < 8; i++) begin
      f[n] = msbf ? d[7-i] : d[i];
      n = n + 1;
    end
    if (pmode != 0) begin
      p = ^d;
      if (pmode == 2) p = ~p;
      f[n] = p ^ flip_par;
      n = n + 1;
    end
    for (int s = 0; s < nstop; s++) begin
      f[n] = (s == nstop - 1) ? last_stop : 1'b1;
      n = n + 1;
    end
  endtask

  task automatic drive_bits(input int which, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(which, f[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int which, input int budget, output bit ok);
    int sz;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sz = (which == 0) ? got_a.size() : (which == 1) ? got_b.size() : got_c.size();
      if (sz > 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_word dut%0d: no word delivered within %0d cycles", which, budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_cycles(3);
    n_cmp++;
    if ({valid_a, pe_a, fe_a, ovr_a, busy_a, data_a} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_a: got %h required 0", {valid_a, pe_a, fe_a, ovr_a, busy_a, data_a});
    end
    n_cmp++;
    if ({valid_b, pe_b, fe_b, ovr_b, busy_b, data_b} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_b: got %h required 0", {valid_b, pe_b, fe_b, ovr_b, busy_b, data_b});
    end
    n_cmp++;
    if ({valid_c, pe_c, fe_c, ovr_c, busy_c, data_c} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_c: got %h required 0", {valid_c, pe_c, fe_c, ovr_c, busy_c, data_c});
    end
    rst = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_basic;
    logic [15:0] f; int n; bit ok; word_t g, e; int v0;
    rx_ready = 1'b1;
    v0 = vcyc_a;
    build_frame(8'hA5, 1'b1, 1, 1'b0, 1, 1'b1, f, n);
    exp_q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    drive_bits(0, f, n);
    wait_got(0, 4 * CPB, ok);
    if (ok) begin
      g = got_a.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL basic_a5: got %h required %h", g, e); end
    end else void'(exp_q.pop_front());
    idle_cycles(CPB);
    n_cmp++;
    if (vcyc_a - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d cycles required 1", vcyc_a - v0); end
  endtask

  task automatic test_odd_lsb;
    logic [15:0] f; int n; bit ok; word_t g, e;
    for (int k = 0; k < 2; k++) begin
      // k=0 sends parity 0 (wrong for odd over 0x3C), k=1 sends the correct 1
      build_frame(8'h3C, 1'b0, 2, (k == 0), 1, 1'b1, f, n);
      exp_q.push_back('{d: 8'h3C, pe: (k == 0), fe: 1'b0});
      drive_bits(1, f, n);
      wait_got(1, 4 * CPB, ok);
      if (ok) begin
        g = got_b.pop_front(); e = exp_q.pop_front();
        n_cmp++;
        if (g !== e) begin n_fail++; $display("FAIL odd_lsb_%0d: got %h required %h", k, g, e); end
      end else void'(exp_q.pop_front());
      idle_cycles(CPB);
    end
  endtask

  task automatic test_two_stop;
    logic [15:0] f; int n; bit ok; word_t g, e;
    build_frame(8'h5B, 1'b1, 1, 1'b0, 2, 1'b0, f, n);
    exp_q.push_back('{d: 8'h5B, pe: 1'b0, fe: 1'b1});
    drive_bits(2, f, n);
    set_rx(2, 1'b1);
    wait_got(2, 4 * CPB, ok);
    if (ok) begin
      g = got_c.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL stop2_frame_err: got %h required %h", g, e); end
    end else void'(exp_q.pop_front());
    idle_cycles(2 * CPB);
    build_frame(8'h00, 1'b1, 1, 1'b0, 2, 1'b1, f, n);
    exp_q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b0});
    drive_bits(2, f, n);
    wait_got(2, 4 * CPB, ok);
    if (ok) begin
      g = got_c.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL stop2_clean: got %h required %h", g, e); end
    end else void'(exp_q.pop_front());
    idle_cycles(CPB);
  endtask

  task automatic test_back_to_back;
    logic [15:0] f1, f2; int n1, n2; bit ok; word_t g, e; int o0;
    rx_ready = 1'b0;
    o0 = ovr_cnt_a;
    build_frame(8'h11, 1'b1, 1, 1'b0, 1, 1'b1, f1, n1);
    build_frame(8'h22, 1'b1, 1, 1'b0, 1, 1'b1, f2, n2);
    exp_q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    drive_bits(0, f1, n1);
    drive_bits(0, f2, n2);
    idle_cycles(CPB);
    n_cmp++;
    if (data_a !== 8'h11) begin n_fail++; $display("FAIL b2b_held_data: got %h required 11", data_a); end
    n_cmp++;
    if (valid_a !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_held: got %b required 1", valid_a); end
    n_cmp++;
    if (ovr_cnt_a - o0 !== 1) begin n_fail++; $display("FAIL b2b_overrun_pulses: got %0d required 1", ovr_cnt_a - o0); end
    n_cmp++;
    if (got_a.size() !== 0) begin n_fail++; $display("FAIL b2b_no_accept: got %0d words required 0", got_a.size()); end
    rx_ready = 1'b1;
    idle_cycles(1);
    n_cmp++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b required 0", valid_a); end
    wait_got(0, 4, ok);
    if (ok) begin
      g = got_a.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_word: got %h required %h", g, e); end
    end else void'(exp_q.pop_front());
    idle_cycles(CPB);
  endtask

  task automatic test_glitch;
    bit saw_busy; int v0;
    saw_busy = 1'b0;
    v0 = vcyc_a;
    rx_a = 1'b0;
    for (int i = 1; i <= HALF + 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) rx_a = 1'b1;
      if (busy_a) saw_busy = 1'b1;
    end
    n_cmp++;
    if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b required 1", saw_busy); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_clear: got %b required 0", busy_a); end
    idle_cycles(12 * CPB);
    n_cmp++;
    if (vcyc_a - v0 !== 0) begin n_fail++; $display("FAIL glitch_no_valid: got %0d valid cycles required 0", vcyc_a - v0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] f; int n; bit ok; word_t g, e; int o0;
    o0 = ovr_cnt_a;
    build_frame(8'h5A, 1'b1, 1, 1'b0, 1, 1'b1, f, n);
    drive_bits(0, f, 4);
    rst = 1'b1;
    rx_a = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    n_cmp++;
    if ({busy_a, valid_a} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_abort: got %b required 00", {busy_a, valid_a}); end
    idle_cycles(12 * CPB);
    n_cmp++;
    if (got_a.size() !== 0) begin n_fail++; $display("FAIL rst_mid_no_word: got %0d words required 0", got_a.size()); end
    build_frame(8'h81, 1'b1, 1, 1'b0, 1, 1'b1, f, n);
    exp_q.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0});
    drive_bits(0, f, n);
    wait_got(0, 4 * CPB, ok);
    if (ok) begin
      g = got_a.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL rst_mid_81: got %h required %h", g, e); end
    end else void'(exp_q.pop_front());
    idle_cycles(CPB);
    n_cmp++;
    if (got_a.size() + (ovr_cnt_a - o0) !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_extra: got %0d extra words/overruns required 0", got_a.size() + (ovr_cnt_a - o0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_lsb();
    test_two_stop();
    test_back_to_back();
    test_glitch();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
